// File: rtl/msu_stream_prefetch_if.sv
// msu_stream_prefetch_if
// SDRAM arbiter port used by the MSU-1 stream prefetcher. Requests use a
// toggle handshake: the master flips ram_req with ram_addr valid, and the
// arbiter answers by making ram_ack equal to ram_req with ram_din valid.
//   ram_addr  master->slave  physical 64-bit line address (byte address [31:3])
//   ram_req   master->slave  toggle request
//   ram_ack   slave->master  toggle acknowledge
//   ram_din   slave->master  64-bit read data, valid in the ack cycle
interface msu_stream_prefetch_if;
  logic [28:0] ram_addr;
  logic        ram_req;
  logic        ram_ack;
  logic [63:0] ram_din;

  modport master (output ram_addr, output ram_req, input ram_ack, input ram_din);
  modport slave  (input ram_addr, input ram_req, output ram_ack, output ram_din);
endinterface

// File: rtl/msu_stream_prefetch.sv
// msu_stream_prefetch
// Serves sequential byte reads of an MSU-1 data/audio stream out of a ring of
// DEPTH 64-bit lines. The ring is kept full ahead of the reader over the
// toggle req/ack SDRAM port, and every logical line is relocated on its own
// past the physical address hole so streams that cross it read correctly.
//   clk_sys, reset_n  clock and asynchronous active-low reset
//   base_addr         byte base of the file in SDRAM ([31:3] used)
//   rd_seek           rising edge: restart the ring at rd_addr
//   rd_seek_done      high once the lines at and after the seek target are held
//   rd_next           rising edge: rd_addr has moved on
//   rd_addr           logical byte address being read
//   rd_valid, rd_dout byte at rd_addr (combinational, zero when not valid)
//   ram               SDRAM arbiter port (master side)
module msu_stream_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [28:0] HOLE_START = 29'h4400000,
  parameter logic [28:0] HOLE_SIZE  = 29'h0100000
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [31:0]                   base_addr,
  input  logic                          rd_seek,
  output logic                          rd_seek_done,
  input  logic                          rd_next,
  input  logic [31:0]                   rd_addr,
  output logic                          rd_valid,
  output logic [7:0]                    rd_dout,
  msu_stream_prefetch_if.master         ram
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_STALE} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [28:0]   addr_q, addr_d;
  logic          done_q, done_d;
  logic          wait_q, wait_d;
  logic          old_seek_q, old_seek_d;
  logic          old_rd_q, old_rd_d;
  logic [28:0]   hl_q, hl_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   ring_q [DEPTH];
  logic [63:0]   ring_d [DEPTH];

  logic [28:0]   line;
  logic          ack_seen;
  logic          seek_edge;
  logic          next_edge;
  logic          fill;
  logic          pop;
  logic          flush;
  logic          free;
  logic [63:0]   head_data;
  logic          unused_base;

  // Logical-to-physical line mapping; each line is checked against the hole
  // individually.
  function automatic logic [28:0] phys_line(input logic [28:0] base_line,
                                            input logic [28:0] log_line);
    logic [28:0] p;
    p = base_line + log_line;
    if (p >= HOLE_START) p = p + HOLE_SIZE;
    return p;
  endfunction

  assign line        = rd_addr[31:3];
  assign unused_base = ^base_addr[2:0];

  // An ack only means something while a request is outstanding; in IDLE
  // req and ack are equal anyway.
  assign ack_seen  = (state_q != ST_IDLE) && (ram.ram_ack == req_q);
  // A seek edge swallows an rd_next edge arriving in the same cycle.
  assign seek_edge = rd_seek && !old_seek_q;
  assign next_edge = rd_next && !old_rd_q && !seek_edge;
  assign fill      = (state_q == ST_FETCH) && ack_seen;
  // Stepping to HL+1 is a pop only if the head line is held or lands now;
  // otherwise the outstanding fetch belongs to the old head and we restart.
  assign pop       = next_edge && (line == hl_q + 29'd1) && ((count_q != '0) || fill);
  assign flush     = seek_edge || (next_edge && (line != hl_q) && !pop);

  assign head_data    = ring_q[head_q];
  assign rd_valid     = (count_q != '0) && (line == hl_q) && (state_q != ST_STALE);
  assign rd_dout      = rd_valid ? head_data[{rd_addr[2:0], 3'b000} +: 8] : 8'h00;
  assign rd_seek_done = done_q;
  assign ram.ram_req  = req_q;
  assign ram.ram_addr = addr_q;

  // Next-state logic: ring bookkeeping, request FSM and seek completion.
  // A request is launched whenever nothing is outstanding after this cycle
  // and the ring has room, including in the very cycle the previous ack lands.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    done_d     = done_q;
    wait_d     = wait_q;
    old_seek_d = rd_seek;
    old_rd_d   = rd_next;
    hl_d       = hl_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ring_d     = ring_q;
    free       = 1'b0;

    if (flush) begin
      hl_d    = line;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fill) begin
        ring_d[tail_q] = ram.ram_din;
        tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
        hl_d   = line;
      end
      count_d = count_q + CW'(fill) - CW'(pop);
    end

    case (state_q)
      ST_IDLE: free = 1'b1;
      ST_FETCH: begin
        if (ack_seen) begin
          free    = 1'b1;
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_STALE;
        end
      end
      ST_STALE: begin
        if (ack_seen) begin
          free    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (free && (count_d < CW'(DEPTH))) begin
      req_d   = ~req_q;
      addr_d  = phys_line(base_addr[31:3], hl_d + 29'(count_d));
      state_d = ST_FETCH;
    end

    if (seek_edge) begin
      done_d = 1'b0;
      wait_d = 1'b1;
    end else if (wait_q && !flush && (count_q >= CW'(2)) && (state_q != ST_STALE)) begin
      done_d = 1'b1;
      wait_d = 1'b0;
    end
  end

  // State registers; ram_req resets to 0 together with the arbiter's ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b1;
      wait_q     <= 1'b0;
      old_seek_q <= 1'b0;
      old_rd_q   <= 1'b0;
      hl_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ring_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      wait_q     <= wait_d;
      old_seek_q <= old_seek_d;
      old_rd_q   <= old_rd_d;
      hl_q       <= hl_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ring_q     <= ring_d;
    end
  end

endmodule

// File: tb/tb_msu_stream_prefetch.sv
// tb_msu_stream_prefetch
// Directed bench for msu_stream_prefetch with a toggle-handshake SDRAM model
// of programmable latency whose data is a fixed function of the line address.
module tb_msu_stream_prefetch;
  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] base_addr;
  logic        rd_seek;
  logic        rd_seek_done;
  logic        rd_next;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_dout;

  int n_checks = 0;
  int n_pass   = 0;

  msu_stream_prefetch_if ram_if ();

  msu_stream_prefetch #(.DEPTH(DEPTH)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .base_addr    (base_addr),
    .rd_seek      (rd_seek),
    .rd_seek_done (rd_seek_done),
    .rd_next      (rd_next),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_dout      (rd_dout),
    .ram          (ram_if)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] ram_byte(input logic [28:0] pline, input int k);
    logic [7:0] lo;
    lo = {pline[4:0], 3'(k)};
    return lo ^ pline[12:5];
  endfunction

  function automatic logic [63:0] ram_word(input logic [28:0] pline);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = ram_byte(pline, k);
    return w;
  endfunction

  function automatic logic [28:0] exp_phys(input logic [31:0] base, input logic [31:0] addr);
    logic [28:0] p;
    p = base[31:3] + addr[31:3];
    if (p >= 29'h4400000) p = p + 29'h0100000;
    return p;
  endfunction

  // SDRAM model: latches a new request at the falling edge, answers lat
  // falling edges later, and counts toggles, acks and protocol violations.
  int          lat = 3;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [28:0] cur_addr;
  logic [28:0] req_log [$];
  int          n_toggles = 0;
  int          n_acks = 0;
  int          proto_err = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      ram_if.ram_ack = 1'b0;
      busy = 1'b0;
      cnt = 0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (ram_if.ram_req != prev_req) begin
        n_toggles++;
        if (prev_req != prev_ack) proto_err++;
      end
      if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          ram_if.ram_din = ram_word(cur_addr);
          ram_if.ram_ack = ram_if.ram_req;
          busy = 1'b0;
          n_acks++;
        end
      end else if (ram_if.ram_req != ram_if.ram_ack) begin
        busy = 1'b1;
        cnt = lat;
        cur_addr = ram_if.ram_addr;
        req_log.push_back(ram_if.ram_addr);
      end
      prev_req = ram_if.ram_req;
      prev_ack = ram_if.ram_ack;
    end
  end

  function automatic logic [28:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return '1;
  endfunction

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if ((ram_if.ram_req === ram_if.ram_ack) && !busy) quiet++;
      else quiet = 0;
      if (quiet >= 12) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (rd_seek_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_seek(input logic [31:0] addr);
    rd_addr = addr;
    rd_seek = 1'b1;
    tick();
    rd_seek = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    base_addr = 32'h0010_0000;
    rd_addr = 32'h10;
    rd_seek = 1'b0;
    rd_next = 1'b0;
    ram_if.ram_ack = 1'b0;
    ram_if.ram_din = '0;
    repeat (3) tick();
    n_checks++; if (ram_if.ram_req !== 1'b0) $display("[TB] FAIL reset_ram_req: got %0b want 0", ram_if.ram_req); else n_pass++;
    n_checks++; if (ram_if.ram_addr !== 29'h0) $display("[TB] FAIL reset_ram_addr: got %h want 0", ram_if.ram_addr); else n_pass++;
    n_checks++; if (rd_seek_done !== 1'b1) $display("[TB] FAIL reset_seek_done: got %0b want 1", rd_seek_done); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", rd_valid); else n_pass++;
    n_checks++; if (rd_dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h want 00", rd_dout); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_seek_read();
    bit ok;
    int a0;
    lat = 3;
    wait_idle(ok);
    n_checks++; if (!ok) $display("[TB] FAIL seek_pre_idle: got timeout want idle"); else n_pass++;
    req_log.delete();
    a0 = n_acks;
    rd_addr = 32'h10;
    rd_seek = 1'b1;
    tick();
    rd_seek = 1'b0;
    n_checks++; if (rd_seek_done !== 1'b0) $display("[TB] FAIL seek_done_low: got %0b want 0", rd_seek_done); else n_pass++;
    n_checks++; if (log_at(0) !== 29'h20002) $display("[TB] FAIL seek_first_line: got %h want 20002", log_at(0)); else n_pass++;
    wait_done(ok);
    n_checks++; if (!ok) $display("[TB] FAIL seek_done_timeout: got timeout want done"); else n_pass++;
    n_checks++; if (n_acks - a0 != 2) $display("[TB] FAIL seek_done_after_acks: got %0d want 2", n_acks - a0); else n_pass++;
    wait_idle(ok);
    n_checks++; if (!ok) $display("[TB] FAIL seek_post_idle: got timeout want idle"); else n_pass++;
    n_checks++; if (req_log.size() != DEPTH) $display("[TB] FAIL seek_lines_fetched: got %0d want %0d", req_log.size(), DEPTH); else n_pass++;
    n_checks++; if (log_at(1) !== 29'h20003) $display("[TB] FAIL seek_second_line: got %h want 20003", log_at(1)); else n_pass++;
    n_checks++; if (log_at(3) !== 29'h20005) $display("[TB] FAIL seek_last_line: got %h want 20005", log_at(3)); else n_pass++;
    n_checks++; if (rd_valid !== 1'b1) $display("[TB] FAIL seek_valid: got %0b want 1", rd_valid); else n_pass++;
    n_checks++; if (rd_dout !== ram_byte(29'h20002, 0)) $display("[TB] FAIL seek_dout: got %h want %h", rd_dout, ram_byte(29'h20002, 0)); else n_pass++;
  endtask

  task automatic test_stream();
    bit ok;
    bit vbad;
    int adv;
    int occ;
    int max_occ;
    logic [31:0] a;
    logic [7:0] exp;
    lat = 2;
    wait_idle(ok);
    req_log.delete();
    pulse_seek(32'h100);
    wait_done(ok);
    n_checks++; if (!ok) $display("[TB] FAIL stream_seek_done: got timeout want done"); else n_pass++;
    adv = 0;
    max_occ = 0;
    for (int i = 0; i < 64; i++) begin
      a = 32'h100 + 32'(i);
      if (i > 0) begin
        rd_addr = a;
        rd_next = 1'b1;
        if (a[2:0] == 3'd0) adv++;
      end
      tick();
      rd_next = 1'b0;
      vbad = (rd_valid !== 1'b1);
      exp = ram_byte(exp_phys(base_addr, a), int'(a[2:0]));
      n_checks++; if (rd_dout !== exp) $display("[TB] FAIL stream_data[%0d]: got %h want %h", i, rd_dout, exp); else n_pass++;
      repeat (3) begin
        tick();
        if (rd_valid !== 1'b1) vbad = 1'b1;
      end
      n_checks++; if (vbad) $display("[TB] FAIL stream_valid[%0d]: got dropped want held 1", i); else n_pass++;
      occ = req_log.size() - adv;
      if (occ > max_occ) max_occ = occ;
    end
    n_checks++; if (max_occ != DEPTH) $display("[TB] FAIL stream_max_buffered: got %0d want %0d", max_occ, DEPTH); else n_pass++;
  endtask

  task automatic test_hole();
    bit ok;
    lat = 3;
    wait_idle(ok);
    base_addr = 32'h0;
    req_log.delete();
    pulse_seek(32'h21FF_FFF8);
    wait_done(ok);
    n_checks++; if (!ok) $display("[TB] FAIL hole_seek_done: got timeout want done"); else n_pass++;
    wait_idle(ok);
    n_checks++; if (log_at(0) !== 29'h43FFFFF) $display("[TB] FAIL hole_first_line: got %h want 43fffff", log_at(0)); else n_pass++;
    n_checks++; if (log_at(1) !== 29'h4500000) $display("[TB] FAIL hole_second_line: got %h want 4500000", log_at(1)); else n_pass++;
    n_checks++; if (log_at(2) !== 29'h4500001) $display("[TB] FAIL hole_third_line: got %h want 4500001", log_at(2)); else n_pass++;
    n_checks++; if (rd_dout !== ram_byte(29'h43FFFFF, 0)) $display("[TB] FAIL hole_dout_before: got %h want %h", rd_dout, ram_byte(29'h43FFFFF, 0)); else n_pass++;
    rd_addr = 32'h2200_0000;
    rd_next = 1'b1;
    tick();
    rd_next = 1'b0;
    n_checks++; if (rd_valid !== 1'b1) $display("[TB] FAIL hole_valid_after: got %0b want 1", rd_valid); else n_pass++;
    n_checks++; if (rd_dout !== ram_byte(29'h4500000, 0)) $display("[TB] FAIL hole_dout_after: got %h want %h", rd_dout, ram_byte(29'h4500000, 0)); else n_pass++;
  endtask

  task automatic test_stale();
    bit ok;
    int t0;
    int k0;
    int p0;
    lat = 3;
    wait_idle(ok);
    base_addr = 32'h0010_0000;
    lat = 10;
    req_log.delete();
    t0 = n_toggles;
    k0 = n_acks;
    p0 = proto_err;
    pulse_seek(32'h2000);
    tick();
    pulse_seek(32'h800B);
    n_checks++; if (rd_seek_done !== 1'b0) $display("[TB] FAIL stale_done_low: got %0b want 0", rd_seek_done); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL stale_valid_low: got %0b want 0", rd_valid); else n_pass++;
    wait_done(ok);
    n_checks++; if (!ok) $display("[TB] FAIL stale_seek_done: got timeout want done"); else n_pass++;
    wait_idle(ok);
    n_checks++; if (log_at(0) !== 29'h20400) $display("[TB] FAIL stale_first_line: got %h want 20400", log_at(0)); else n_pass++;
    n_checks++; if (log_at(1) !== 29'h21001) $display("[TB] FAIL stale_refetch_line: got %h want 21001", log_at(1)); else n_pass++;
    n_checks++; if (rd_dout !== ram_byte(29'h21001, 3)) $display("[TB] FAIL stale_dout: got %h want %h", rd_dout, ram_byte(29'h21001, 3)); else n_pass++;
    n_checks++; if ((n_toggles - t0) != (n_acks - k0)) $display("[TB] FAIL stale_toggle_vs_ack: got %0d toggles want %0d", n_toggles - t0, n_acks - k0); else n_pass++;
    n_checks++; if (proto_err != p0) $display("[TB] FAIL stale_protocol: got %0d violations want 0", proto_err - p0); else n_pass++;
  endtask

  task automatic test_jump();
    bit ok;
    lat = 3;
    req_log.delete();
    rd_addr = 32'h804B;
    rd_next = 1'b1;
    tick();
    rd_next = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL jump_valid_low: got %0b want 0", rd_valid); else n_pass++;
    n_checks++; if (rd_seek_done !== 1'b1) $display("[TB] FAIL jump_done_kept: got %0b want 1", rd_seek_done); else n_pass++;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("[TB] FAIL jump_refill: got timeout want valid"); else n_pass++;
    n_checks++; if (rd_dout !== ram_byte(29'h21009, 3)) $display("[TB] FAIL jump_dout: got %h want %h", rd_dout, ram_byte(29'h21009, 3)); else n_pass++;
    n_checks++; if (log_at(0) !== 29'h21009) $display("[TB] FAIL jump_line: got %h want 21009", log_at(0)); else n_pass++;
    n_checks++; if (rd_seek_done !== 1'b1) $display("[TB] FAIL jump_done_after: got %0b want 1", rd_seek_done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_idle(ok);
    lat = 10;
    pulse_seek(32'h18);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_checks++; if (ram_if.ram_req !== 1'b0) $display("[TB] FAIL rstmid_ram_req: got %0b want 0", ram_if.ram_req); else n_pass++;
    n_checks++; if (ram_if.ram_addr !== 29'h0) $display("[TB] FAIL rstmid_ram_addr: got %h want 0", ram_if.ram_addr); else n_pass++;
    n_checks++; if (rd_seek_done !== 1'b1) $display("[TB] FAIL rstmid_seek_done: got %0b want 1", rd_seek_done); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL rstmid_valid: got %0b want 0", rd_valid); else n_pass++;
    n_checks++; if (rd_dout !== 8'h00) $display("[TB] FAIL rstmid_dout: got %h want 00", rd_dout); else n_pass++;
    repeat (3) tick();
    reset_n = 1'b1;
    lat = 3;
    wait_idle(ok);
    n_checks++; if (!ok) $display("[TB] FAIL rstmid_idle: got timeout want idle"); else n_pass++;
    req_log.delete();
    pulse_seek(32'h18);
    wait_done(ok);
    n_checks++; if (!ok) $display("[TB] FAIL rstmid_seek_done_after: got timeout want done"); else n_pass++;
    n_checks++; if (log_at(0) !== 29'h20003) $display("[TB] FAIL rstmid_line: got %h want 20003", log_at(0)); else n_pass++;
    n_checks++; if (rd_dout !== ram_byte(29'h20003, 0)) $display("[TB] FAIL rstmid_dout_after: got %h want %h", rd_dout, ram_byte(29'h20003, 0)); else n_pass++;
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_seek_read();
    test_stream();
    test_hole();
    test_stale();
    test_jump();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a run that never reaches the summary.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
